// File: rtl/ps2_key_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: protocol bytes,
// FSM state encoding and the frame parity helper.
package ps2_key_rx_pkg;

   // Break prefix sent before the scan code of a released key.
   localparam logic [7:0] PS2_BREAK = 8'hF0;
   // Extended-key prefix; it is received as an ordinary byte.
   localparam logic [7:0] PS2_EXT   = 8'hE0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_e;

   // PS/2 frames carry odd parity: data bits plus parity bit hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data_byte, input logic parity_bit);
      return ^{data_byte, parity_bit};
   endfunction

   // True for the two prefix bytes a keyboard may send ahead of a scan code.
   function automatic logic is_prefix(input logic [7:0] data_byte);
      return (data_byte == PS2_BREAK) || (data_byte == PS2_EXT);
   endfunction

endpackage

// File: rtl/ps2_key_rx_sync_filter.sv
// Synchronises the asynchronous PS/2 pins, debounces the PS/2 clock and
// emits a one-cycle pulse on each falling edge of the filtered clock.
module ps2_sync_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic fall,
   output logic data_s
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [SYNC_STAGES-1:0] clk_sync_r;
   logic [SYNC_STAGES-1:0] data_sync_r;
   logic [CW-1:0]          filt_cnt_r;
   logic                   clk_filt_r;
   logic                   fall_r;

   // Synchroniser chains; both idle lines reset high.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync_r  <= {SYNC_STAGES{1'b1}};
         data_sync_r <= {SYNC_STAGES{1'b1}};
      end else begin
         clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
         data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
      end
   end

   // Filtered clock follows the synchronised clock only after FILTER_LEN equal samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         filt_cnt_r <= {CW{1'b0}};
         clk_filt_r <= 1'b1;
         fall_r     <= 1'b0;
      end else if (clk_sync_r[SYNC_STAGES-1] != clk_filt_r) begin
         if (filt_cnt_r == CW'(FILTER_LEN - 1)) begin
            filt_cnt_r <= {CW{1'b0}};
            clk_filt_r <= clk_sync_r[SYNC_STAGES-1];
            fall_r     <= ~clk_sync_r[SYNC_STAGES-1];
         end else begin
            filt_cnt_r <= filt_cnt_r + CW'(1);
            fall_r     <= 1'b0;
         end
      end else begin
         filt_cnt_r <= {CW{1'b0}};
         fall_r     <= 1'b0;
      end
   end

   assign fall   = fall_r;
   assign data_s = data_sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames, checks odd parity and the
// stop bit, and keeps the last two good bytes in key.
// Optional feature macro PS2_TIMEOUT_EN: aborts a frame that stalls mid-way.
module ps2_key_rx
   import ps2_key_rx_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [15:0] key,
   output logic        key_valid,
   output logic        key_release,
   output logic        frame_err,
   output logic        busy
);

   ps2_state_e  state_r, state_nxt;
   logic        fall_s, data_s;
   logic [2:0]  cnt_r;
   logic [7:0]  shift_r;
   logic        parity_r;
   logic        good_s, err_s, timeout_s;
   logic [15:0] key_r;
   logic        key_valid_r, key_release_r, frame_err_r, busy_r;

   ps2_sync_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_sync_filter (
      .clk      (clk),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .fall     (fall_s),
      .data_s   (data_s)
   );

`ifdef PS2_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] to_cnt_r;

   // Idle-time counter: cleared by every falling edge, runs only inside a frame.
   always_ff @(posedge clk) begin
      if (reset || fall_s || (state_r == ST_IDLE)) begin
         to_cnt_r <= {TW{1'b0}};
      end else if (to_cnt_r != TW'(TIMEOUT_CYCLES - 1)) begin
         to_cnt_r <= to_cnt_r + TW'(1);
      end else begin
         to_cnt_r <= to_cnt_r;
      end
   end

   assign timeout_s = (state_r != ST_IDLE) && !fall_s && (to_cnt_r == TW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_s;
   assign unused_timeout_s = ^TIMEOUT_CYCLES;
   assign timeout_s        = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt;
      end
   end

   // Next-state and frame verdict; the FSM moves only on filtered falling edges.
   always_comb begin
      state_nxt = state_r;
      good_s    = 1'b0;
      err_s     = 1'b0;
      if (timeout_s) begin
         state_nxt = ST_IDLE;
         err_s     = 1'b1;
      end else if (fall_s) begin
         case (state_r)
            ST_IDLE: begin
               if (data_s == 1'b0) state_nxt = ST_DATA;
               else                state_nxt = ST_IDLE;
            end
            ST_DATA: begin
               if (cnt_r == 3'd7) state_nxt = ST_PARITY;
               else               state_nxt = ST_DATA;
            end
            ST_PARITY: state_nxt = ST_STOP;
            ST_STOP: begin
               state_nxt = ST_IDLE;
               if (data_s && odd_parity_ok(shift_r, parity_r)) good_s = 1'b1;
               else                                            err_s  = 1'b1;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end else begin
         state_nxt = state_r;
      end
   end

   // Bit counter, LSB-first shifter and parity capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r    <= 3'd0;
         shift_r  <= 8'h00;
         parity_r <= 1'b0;
      end else if (fall_s && !timeout_s) begin
         case (state_r)
            ST_IDLE: begin
               cnt_r   <= 3'd0;
               shift_r <= 8'h00;
            end
            ST_DATA: begin
               shift_r <= {data_s, shift_r[7:1]};
               cnt_r   <= cnt_r + 3'd1;
            end
            ST_PARITY: parity_r <= data_s;
            default:   cnt_r    <= cnt_r;
         endcase
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Registered outputs: key history, result pulses and busy flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         key_r         <= 16'h0000;
         key_valid_r   <= 1'b0;
         key_release_r <= 1'b0;
         frame_err_r   <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         if (good_s) key_r <= {key_r[7:0], shift_r};
         else        key_r <= key_r;
         key_valid_r   <= good_s;
         key_release_r <= good_s && (key_r[7:0] == PS2_BREAK);
         frame_err_r   <= err_s;
         busy_r        <= (state_nxt != ST_IDLE);
      end
   end

   assign key         = key_r;
   assign key_valid   = key_valid_r;
   assign key_release = key_release_r;
   assign frame_err   = frame_err_r;
   assign busy        = busy_r;

endmodule
